dtcm_mc_arbiter: RTL and testbench



---
 rtl/sophon_pkg.sv | 23 ++
 rtl/dtcm_arb_pick.sv | 59 +++++
 rtl/dtcm_mc_arbiter.sv | 114 +++++++++++
 tb/tb_dtcm_mc_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sophon_pkg.sv
// SOPHON shared types: LSU request/response bundles and DTCM arbiter modes.
package SOPHON_PKG;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [3:0]  strb;
    } lsu_req_t;

    typedef struct packed {
        logic        ack;
        logic        error;
        logic [31:0] rdata;
    } lsu_ack_t;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

endpackage

// File: rtl/dtcm_arb_pick.sv
// DTCM grant picker: fixed priority (highest index) or round-robin
// starting one past the pointer.
module dtcm_arb_pick
    import SOPHON_PKG::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ARB_MODE = 1,
    localparam int IW      = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] elig_i,
    input  logic [IW-1:0]     ptr_i,
    output logic [NUM_CH-1:0] gnt_oh_o,
    output logic [IW-1:0]     gnt_idx_o,
    output logic              gnt_vld_o
);

    logic [NUM_CH-1:0] upper;

    always_comb begin
        upper = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            upper[i] = elig_i[i] && (IW'(i) > ptr_i);
        end
    end

    // Round-robin: lowest eligible above the pointer, else lowest overall.
    always_comb begin
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        if (ARB_MODE == int'(ARB_FIXED)) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (elig_i[i]) begin
                    gnt_idx_o = IW'(i);
                    gnt_vld_o = 1'b1;
                end
            end
        end else begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (elig_i[i]) begin
                    gnt_idx_o = IW'(i);
                    gnt_vld_o = 1'b1;
                end
            end
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (upper[i]) begin
                    gnt_idx_o = IW'(i);
                end
            end
        end
    end

    always_comb begin
        gnt_oh_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            gnt_oh_o[i] = gnt_vld_o && (gnt_idx_o == IW'(i));
        end
    end

endmodule

// File: rtl/dtcm_mc_arbiter.sv
// Multi-channel DTCM arbiter with one-cycle registered ack.
// Optional macro DTCM_ARB_RANGE_CHECK_EN adds address window checking.
module dtcm_mc_arbiter
    import SOPHON_PKG::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ARB_MODE = 1,
    parameter int DTCM_AW  = 14
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  lsu_req_t    ch_req_i [NUM_CH],
    output lsu_ack_t    ch_ack_o [NUM_CH],
    output logic        dtcm_req,
    output logic [31:0] dtcm_addr,
    output logic [31:0] dtcm_wdata,
    output logic        dtcm_we,
    output logic [3:0]  dtcm_be,
    input  logic [31:0] dtcm_rdata
);

    localparam int IW = $clog2(NUM_CH);

    if (NUM_CH < 2 || NUM_CH > 8 || DTCM_AW < 2 || DTCM_AW > 31) begin : g_bad_cfg
        $error("dtcm_mc_arbiter: unsupported NUM_CH or DTCM_AW");
    end

    logic              vld_q, vld_d;
    logic              err_q, err_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [NUM_CH-1:0] elig;
    logic [NUM_CH-1:0] gnt_oh;
    logic [IW-1:0]     gnt_idx;
    logic              gnt_vld;
    lsu_req_t          sel;
    logic              oor;
    logic              go;

    // A channel with an access in flight sits out its ack cycle.
    always_comb begin
        elig = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            elig[i] = ch_req_i[i].req && !rst_i
                      && !(vld_q && gidx_q == IW'(i));
        end
    end

    dtcm_arb_pick #(
        .NUM_CH   (NUM_CH),
        .ARB_MODE (ARB_MODE)
    ) u_pick (
        .elig_i    (elig),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_oh[i]) begin
                sel = ch_req_i[i];
            end
        end
    end

`ifdef DTCM_ARB_RANGE_CHECK_EN
    assign oor = (sel.addr >> DTCM_AW) != 32'd0;
`else
    assign oor = 1'b0;
`endif

    assign go         = gnt_vld && sel.req && !oor;
    assign dtcm_req   = go;
    assign dtcm_addr  = go ? sel.addr  : 32'd0;
    assign dtcm_wdata = go ? sel.wdata : 32'd0;
    assign dtcm_we    = go && sel.we;
    assign dtcm_be    = go ? sel.strb  : 4'd0;

    always_comb begin
        vld_d  = gnt_vld;
        gidx_d = gnt_idx;
        err_d  = gnt_vld && oor;
        ptr_d  = gnt_vld ? gnt_idx : ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q  <= 1'b0;
            err_q  <= 1'b0;
            gidx_q <= '0;
            ptr_q  <= IW'(NUM_CH - 1);
        end else begin
            vld_q  <= vld_d;
            err_q  <= err_d;
            gidx_q <= gidx_d;
            ptr_q  <= ptr_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_ack_o[i] = '0;
            if (vld_q && !rst_i && gidx_q == IW'(i)) begin
                ch_ack_o[i].ack   = 1'b1;
                ch_ack_o[i].error = err_q;
                ch_ack_o[i].rdata = err_q ? 32'd0 : dtcm_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dtcm_mc_arbiter.sv
// Bench for dtcm_mc_arbiter: directed scenarios plus a randomized run
// compared every cycle against a behavioural model.
module tb_dtcm_mc_arbiter;
    import SOPHON_PKG::*;

    localparam int N  = 4;
    localparam int AW = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    lsu_req_t    a_req [N];
    lsu_ack_t    a_ack [N];
    logic        a_dreq, a_dwe;
    logic [31:0] a_daddr, a_dwdata, a_drdata;
    logic [3:0]  a_dbe;

    lsu_req_t    b_req [2];
    lsu_ack_t    b_ack [2];
    logic        b_dreq, b_dwe;
    logic [31:0] b_daddr, b_dwdata, b_drdata;
    logic [3:0]  b_dbe;
    assign b_drdata = 32'h1234_5678;

    int checks = 0;
    int failures = 0;

    logic [31:0] sram   [256];
    logic [31:0] shadow [256];

    dtcm_mc_arbiter #(.NUM_CH(N), .ARB_MODE(1), .DTCM_AW(AW)) u_a (
        .clk_i(clk), .rst_i(rst), .ch_req_i(a_req), .ch_ack_o(a_ack),
        .dtcm_req(a_dreq), .dtcm_addr(a_daddr), .dtcm_wdata(a_dwdata),
        .dtcm_we(a_dwe), .dtcm_be(a_dbe), .dtcm_rdata(a_drdata)
    );

    dtcm_mc_arbiter #(.NUM_CH(2), .ARB_MODE(0), .DTCM_AW(AW)) u_b (
        .clk_i(clk), .rst_i(rst), .ch_req_i(b_req), .ch_ack_o(b_ack),
        .dtcm_req(b_dreq), .dtcm_addr(b_daddr), .dtcm_wdata(b_dwdata),
        .dtcm_we(b_dwe), .dtcm_be(b_dbe), .dtcm_rdata(b_drdata)
    );

    // SRAM behind instance A: read-before-write, data one cycle later
    always @(posedge clk) begin
        if (a_dreq) begin
            a_drdata <= sram[a_daddr[9:2]];
            for (int b = 0; b < 4; b++) begin
                if (a_dbe[b] && a_dwe) begin
                    sram[a_daddr[9:2]][8*b +: 8] <= a_dwdata[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Behavioural model of instance A
    int          m_ptr = N - 1, n_ptr = N - 1;
    int          m_g = 0, n_g = 0;
    bit          m_vld = 0, n_vld = 0;
    bit          m_err = 0, n_err = 0;
    logic [31:0] m_rd = '0, n_rd = '0;

    always @(negedge clk) begin
        bit          any;
        bit          oor;
        int          g;
        int          c;
        logic [69:0] eb;
        logic [33:0] ea;
        any = 0;
        oor = 0;
        g   = 0;
        if (!rst) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_ptr + k) % N;
                if (!any && a_req[c].req && !(m_vld && m_g == c)) begin
                    any = 1;
                    g   = c;
                end
            end
        end
`ifdef DTCM_ARB_RANGE_CHECK_EN
        if (any) oor = (a_req[g].addr >> AW) != 0;
`endif
        eb = '0;
        if (any && !oor) begin
            eb = {1'b1, a_req[g].we, a_req[g].strb,
                  a_req[g].addr, a_req[g].wdata};
        end
        chk("dtcm_bus", {a_dreq, a_dwe, a_dbe, a_daddr, a_dwdata}, eb);
        for (int i = 0; i < N; i++) begin
            ea = '0;
            if (!rst && m_vld && m_g == i) begin
                ea = {1'b1, m_err, m_err ? 32'd0 : m_rd};
            end
            chk($sformatf("ack%0d", i), a_ack[i], ea);
        end
        if (rst) begin
            n_vld = 0;
            n_err = 0;
            n_g   = 0;
            n_ptr = N - 1;
        end else begin
            n_vld = any;
            n_g   = g;
            n_err = oor;
            n_ptr = any ? g : m_ptr;
            if (any && !oor) begin
                n_rd = shadow[a_req[g].addr[9:2]];
                for (int b = 0; b < 4; b++) begin
                    if (a_req[g].we && a_req[g].strb[b]) begin
                        shadow[a_req[g].addr[9:2]][8*b +: 8] =
                            a_req[g].wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        m_vld <= n_vld;
        m_g   <= n_g;
        m_err <= n_err;
        m_ptr <= n_ptr;
        m_rd  <= n_rd;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic lsu_req_t mk(input logic [31:0] addr,
                                    input logic we,
                                    input logic [31:0] wd);
        lsu_req_t r;
        r.req   = 1'b1;
        r.addr  = addr;
        r.we    = we;
        r.wdata = wd;
        r.strb  = 4'hF;
        return r;
    endfunction

    function automatic lsu_req_t rand_req();
        lsu_req_t r;
        r.req   = 1'b1;
        r.we    = 1'($urandom_range(0, 1));
        r.strb  = 4'($urandom);
        r.wdata = $urandom;
        r.addr  = 32'($urandom_range(0, 255)) << 2;
        if ($urandom_range(0, 7) == 0) r.addr[14 + $urandom_range(0, 17)] = 1'b1;
        return r;
    endfunction

    int rr_exp [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    bit pend [N];
    bit seen [N];

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 256; i++) begin
            sram[i]   = 32'(i) * 32'h0101_0101;
            shadow[i] = 32'(i) * 32'h0101_0101;
        end
        for (int i = 0; i < N; i++) begin
            a_req[i] = '0;
            pend[i]  = 0;
            seen[i]  = 0;
        end
        b_req[0] = '0;
        b_req[1] = '0;
        repeat (3) step();
        @(negedge clk);
        chk("rst_dreq", a_dreq, 1'b0);
        chk("rst_ack0", a_ack[0], 34'd0);

        // round-robin with all four requesting continuously
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) a_req[i] = mk(32'(i * 4), 1'b0, 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("rr_grant%0d", k), {a_dreq, a_daddr},
                {1'b1, 32'(rr_exp[k] * 4)});
            if (k > 0) chk($sformatf("rr_ack%0d", k), a_ack[rr_exp[k-1]].ack, 1'b1);
            step();
        end
        for (int i = 0; i < N; i++) a_req[i] = '0;
        step();

        // write then read back through another channel
        a_req[0] = mk(32'h100, 1'b1, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("wr_bus", {a_dreq, a_dwe, a_dbe, a_daddr},
            {1'b1, 1'b1, 4'hF, 32'h100});
        step();
        @(negedge clk);
        chk("wr_ack", a_ack[0].ack, 1'b1);
        step();
        a_req[0] = '0;
        a_req[1] = mk(32'h100, 1'b0, 32'd0);
        @(negedge clk);
        chk("rd_bus", {a_dreq, a_dwe, a_daddr}, {1'b1, 1'b0, 32'h100});
        step();
        @(negedge clk);
        chk("rd_ack", a_ack[1], {1'b1, 1'b0, 32'hDEAD_BEEF});
        step();
        a_req[1] = '0;

        // access just outside the decoded window
        step();
        a_req[0] = mk(32'h0000_4000, 1'b1, 32'h55);
        @(negedge clk);
`ifdef DTCM_ARB_RANGE_CHECK_EN
        chk("oor_dreq", {a_dreq, a_dwe}, 2'b00);
`else
        chk("oor_dreq", {a_dreq, a_dwe}, 2'b11);
`endif
        step();
        @(negedge clk);
`ifdef DTCM_ARB_RANGE_CHECK_EN
        chk("oor_ack", a_ack[0], {1'b1, 1'b1, 32'd0});
`else
        chk("oor_ack", a_ack[0][33:32], 2'b10);
`endif
        step();
        a_req[0] = '0;

        // reset while ch2 access is in flight
        step();
        a_req[2] = mk(32'h8, 1'b0, 32'd0);
        @(negedge clk);
        chk("rf_grant", {a_dreq, a_daddr}, {1'b1, 32'h8});
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rf_noack1", a_ack[2], 34'd0);
        step();
        @(negedge clk);
        chk("rf_noack2", a_ack[2], 34'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rf_regrant", {a_dreq, a_daddr}, {1'b1, 32'h8});
        step();
        @(negedge clk);
        chk("rf_ack", a_ack[2].ack, 1'b1);
        step();
        a_req[2] = '0;

        // two channels, fixed priority
        b_req[0] = mk(32'h10, 1'b0, 32'd0);
        b_req[1] = mk(32'h20, 1'b0, 32'd0);
        @(negedge clk);
        chk("fx_c0", {b_dreq, b_daddr}, {1'b1, 32'h20});
        step();
        @(negedge clk);
        chk("fx_c1_ack", b_ack[1], {1'b1, 1'b0, 32'h1234_5678});
        chk("fx_c1_gnt", {b_dreq, b_daddr}, {1'b1, 32'h10});
        step();
        b_req[1] = '0;
        @(negedge clk);
        chk("fx_c2_ack0", b_ack[0], {1'b1, 1'b0, 32'h1234_5678});
        chk("fx_c2_ack1", b_ack[1], 34'd0);
        chk("fx_c2_dreq", b_dreq, 1'b0);
        step();
        b_req[0] = '0;

        // randomized traffic with occasional resets
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(0, 249) == 0) begin
                rst = 1'b1;
                for (int i = 0; i < N; i++) begin
                    a_req[i] = '0;
                    pend[i]  = 0;
                end
            end
            if (!rst) begin
                for (int i = 0; i < N; i++) begin
                    if (pend[i] && seen[i]) begin
                        pend[i]  = 0;
                        a_req[i] = '0;
                    end else if (pend[i] && $urandom_range(0, 39) == 0) begin
                        pend[i]      = 0;
                        a_req[i].req = 1'b0;
                    end
                    if (!pend[i] && $urandom_range(0, 2) == 0) begin
                        a_req[i] = rand_req();
                        pend[i]  = 1;
                    end
                end
            end
            @(negedge clk);
            for (int i = 0; i < N; i++) seen[i] = a_ack[i].ack;
        end
        step();
        for (int i = 0; i < N; i++) a_req[i] = '0;
        rst = 1'b0;
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
